// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg
//   Shared definitions for the single-clock FIFO:
//   - default width constants used as parameter defaults by sync_fifo
//   - fifo_status_t, a packed bundle of the status/error flags for consumers
//     that want to carry them around as one field.
package sync_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 4;

    typedef struct packed {
        logic full;
        logic almost_full;
        logic empty;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram
//   Single-clock dual-port storage for sync_fifo: synchronous write port and
//   a combinational read port. The array has no reset.
// Ports:
//   clock          rising-edge clock
//   write_enable   store write_data at write_address on the next edge
//   write_address  write location
//   write_data     word to store
//   read_address   read location
//   read_data      word at read_address (combinational)
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     write_enable,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0]    read_data
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_address] <= write_data;
        end
    end

    assign read_data = mem[read_address];

endmodule : sync_fifo_ram

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock parametrised FIFO with occupancy count, almost-full /
//   almost-empty thresholds, synchronous flush and sticky overflow/underflow.
//   Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through reads;
//   otherwise read_data is registered with a one-cycle read_valid pulse.
// Ports:
//   clock, reset (sync, active-low), flush
//   write_data, write_increment, full, almost_full
//   read_increment, read_data, read_valid, empty, almost_empty
//   count (0..DEPTH), clear_errors, overflow, underflow
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH      = DEFAULT_ADDRESS_WIDTH,
    parameter int ALMOST_FULL_LEVEL  = 2 ** ADDRESS_WIDTH - 2,
    parameter int ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   write_increment,
    output logic                   full,
    output logic                   almost_full,
    input  logic                   read_increment,
    output logic [DATA_WIDTH-1:0]  read_data,
    output logic                   read_valid,
    output logic                   empty,
    output logic                   almost_empty,
    output logic [ADDRESS_WIDTH:0] count,
    input  logic                   clear_errors,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [ADDRESS_WIDTH:0] PTR_ONE     = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDRESS_WIDTH:0] DEPTH_COUNT = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0] AF_LEVEL    = (ADDRESS_WIDTH+1)'(ALMOST_FULL_LEVEL);
    localparam logic [ADDRESS_WIDTH:0] AE_LEVEL    = (ADDRESS_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDRESS_WIDTH:0] write_pointer_q, write_pointer_d;
    logic [ADDRESS_WIDTH:0] read_pointer_q,  read_pointer_d;
    logic [ADDRESS_WIDTH:0] count_q,         count_d;
    logic full_q,         full_d;
    logic empty_q,        empty_d;
    logic almost_full_q,  almost_full_d;
    logic almost_empty_q, almost_empty_d;
    logic overflow_q,     overflow_d;
    logic underflow_q,    underflow_d;
    logic write_accept;
    logic read_accept;
    logic [DATA_WIDTH-1:0] ram_read_data;

    sync_fifo_ram #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_ram (
        .clock         (clock),
        .write_enable  (write_accept),
        .write_address (write_pointer_q[ADDRESS_WIDTH-1:0]),
        .write_data    (write_data),
        .read_address  (read_pointer_q[ADDRESS_WIDTH-1:0]),
        .read_data     (ram_read_data)
    );

    always_comb begin
        // Acceptance looks only at registered flags; flush swallows requests.
        write_accept = write_increment && !full_q  && !flush;
        read_accept  = read_increment  && !empty_q && !flush;

        write_pointer_d = write_pointer_q;
        read_pointer_d  = read_pointer_q;
        if (flush) begin
            write_pointer_d = '0;
            read_pointer_d  = '0;
        end else begin
            if (write_accept) write_pointer_d = write_pointer_q + PTR_ONE;
            if (read_accept)  read_pointer_d  = read_pointer_q + PTR_ONE;
        end

        // All status flags derive from the next-state count so they agree.
        count_d        = write_pointer_d - read_pointer_d;
        full_d         = (count_d == DEPTH_COUNT);
        empty_d        = (count_d == '0);
        almost_full_d  = (count_d >= AF_LEVEL);
        almost_empty_d = (count_d <= AE_LEVEL);

        // A new error in the same cycle as clear_errors keeps the flag set.
        overflow_d  = (write_increment && full_q  && !flush) || (overflow_q  && !clear_errors);
        underflow_d = (read_increment  && empty_q && !flush) || (underflow_q && !clear_errors);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            write_pointer_q <= '0;
            read_pointer_q  <= '0;
            count_q         <= '0;
            full_q          <= 1'b0;
            empty_q         <= 1'b1;
            almost_full_q   <= 1'b0;
            almost_empty_q  <= 1'b1;
            overflow_q      <= 1'b0;
            underflow_q     <= 1'b0;
        end else begin
            write_pointer_q <= write_pointer_d;
            read_pointer_q  <= read_pointer_d;
            count_q         <= count_d;
            full_q          <= full_d;
            empty_q         <= empty_d;
            almost_full_q   <= almost_full_d;
            almost_empty_q  <= almost_empty_d;
            overflow_q      <= overflow_d;
            underflow_q     <= underflow_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is presented directly; masked to zero while nothing is stored.
    assign read_data  = empty_q ? '0 : ram_read_data;
    assign read_valid = !empty_q;
`else
    logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
    logic                  read_valid_q, read_valid_d;

    always_comb begin
        read_data_d  = read_accept ? ram_read_data : read_data_q;
        read_valid_d = read_accept;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
`endif

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
//   Self-checking bench for sync_fifo (DATA_WIDTH=8, ADDRESS_WIDTH=2,
//   ALMOST_FULL_LEVEL=3, ALMOST_EMPTY_LEVEL=1). A queue-based reference model
//   predicts every output each cycle; directed steps follow the test plan,
//   then randomized traffic runs. Honors SYNC_FIFO_FWFT_EN when defined.
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int AEL   = 1;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          flush;
    logic [DW-1:0] write_data;
    logic          write_increment;
    logic          full;
    logic          almost_full;
    logic          read_increment;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          clear_errors;
    logic          overflow;
    logic          underflow;

    sync_fifo #(
        .DATA_WIDTH         (DW),
        .ADDRESS_WIDTH      (AW),
        .ALMOST_FULL_LEVEL  (AFL),
        .ALMOST_EMPTY_LEVEL (AEL)
    ) dut (
        .clock           (clock),
        .reset           (reset_n),
        .flush           (flush),
        .write_data      (write_data),
        .write_increment (write_increment),
        .full            (full),
        .almost_full     (almost_full),
        .read_increment  (read_increment),
        .read_data       (read_data),
        .read_valid      (read_valid),
        .empty           (empty),
        .almost_empty    (almost_empty),
        .count           (count),
        .clear_errors    (clear_errors),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // Reference model state
    logic [DW-1:0] m_q[$];
    bit            m_ov = 1'b0;
    bit            m_un = 1'b0;
    bit            m_rv = 1'b0;
    logic [DW-1:0] m_rd = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst_n, input bit fl, input bit wi, input bit ri,
                              input bit clr, input logic [DW-1:0] wd);
        bit was_full, was_empty;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (!rst_n) begin
            m_q.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_rv = 1'b0;
            m_rd = '0;
        end else if (fl) begin
            m_q.delete();
            m_rv = 1'b0;
            m_ov = m_ov && !clr;
            m_un = m_un && !clr;
        end else begin
            m_ov = (wi && was_full)  || (m_ov && !clr);
            m_un = (ri && was_empty) || (m_un && !clr);
            m_rv = ri && !was_empty;
            if (ri && !was_empty) m_rd = m_q.pop_front();
            if (wi && !was_full)  m_q.push_back(wd);
        end
    endtask

    task automatic compare_all();
        int sz;
        sz = m_q.size();
        check("count",        32'(count),        32'(sz));
        check("full",         32'(full),         32'(sz == DEPTH));
        check("empty",        32'(empty),        32'(sz == 0));
        check("almost_full",  32'(almost_full),  32'(sz >= AFL));
        check("almost_empty", 32'(almost_empty), 32'(sz <= AEL));
        check("overflow",     32'(overflow),     32'(m_ov));
        check("underflow",    32'(underflow),    32'(m_un));
`ifdef SYNC_FIFO_FWFT_EN
        check("read_valid",   32'(read_valid),   32'(sz != 0));
        if (sz != 0) check("read_data", 32'(read_data), 32'(m_q[0]));
        else         check("read_data", 32'(read_data), 32'(0));
`else
        check("read_valid",   32'(read_valid),   32'(m_rv));
        check("read_data",    32'(read_data),    32'(m_rd));
`endif
    endtask

    // One clock of stimulus: drive, advance the model at the edge, compare #1 later.
    task automatic step(input bit rst_n, input bit fl, input bit wi, input bit ri,
                        input bit clr, input logic [DW-1:0] wd);
        reset_n         = rst_n;
        flush           = fl;
        write_increment = wi;
        read_increment  = ri;
        clear_errors    = clr;
        write_data      = wd;
        @(posedge clock);
        model_edge(rst_n, fl, wi, ri, clr, wd);
        #1;
        compare_all();
        $display("cyc %0d rst_n=%b fl=%b wr=%b rd=%b clr=%b wd=%02h -> count=%0d rdata=%02h rv=%b ov=%b un=%b",
                 cycle, rst_n, fl, wi, ri, clr, wd, count, read_data, read_valid, overflow, underflow);
        cycle++;
    endtask

    logic [DW-1:0] exp_r [4];
    logic [DW-1:0] exp_w [8];

    initial begin
        reset_n = 1'b0; flush = 1'b0; write_increment = 1'b0; read_increment = 1'b0;
        clear_errors = 1'b0; write_data = '0;
        exp_r[0] = 8'h11; exp_r[1] = 8'h22; exp_r[2] = 8'h33; exp_r[3] = 8'h44;
        exp_w[0] = 8'h90; exp_w[1] = 8'h91; exp_w[2] = 8'hA0; exp_w[3] = 8'hA1;
        exp_w[4] = 8'hA2; exp_w[5] = 8'hA3; exp_w[6] = 8'hA4; exp_w[7] = 8'hA5;
        @(negedge clock);

        // Reset
        step(0, 0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 1, 0, 8'hEE);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_read_data",    32'(read_data),    32'd0);

        // Fill 0x11..0x44, then overflow attempt
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, exp_r[i]);
        check("fill_full", 32'(full), 32'd1);
        step(1, 0, 1, 0, 0, 8'h99);
        check("fill_overflow", 32'(overflow), 32'd1);
        check("fill_count",    32'(count),    32'd4);

        // Drain 4, then underflow attempt
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0, 1, 0, 8'h00);
`ifndef SYNC_FIFO_FWFT_EN
            check("drain_data",  32'(read_data),  32'(exp_r[i]));
            check("drain_valid", 32'(read_valid), 32'd1);
`endif
        end
        step(1, 0, 0, 1, 0, 8'h00);
        check("drain_underflow", 32'(underflow), 32'd1);
`ifndef SYNC_FIFO_FWFT_EN
        check("drain_hold", 32'(read_data), 32'h44);
`endif
        step(1, 0, 0, 0, 1, 8'h00);

        // Fill to 2, then 6 simultaneous read+write across pointer wrap
        step(1, 0, 1, 0, 0, exp_w[0]);
        step(1, 0, 1, 0, 0, exp_w[1]);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 1, 1, 0, exp_w[i+2]);
            check("wrap_count", 32'(count), 32'd2);
`ifndef SYNC_FIFO_FWFT_EN
            check("wrap_order", 32'(read_data), 32'(exp_w[i]));
`endif
        end

        // Fill to full, then simultaneous read + write 0x55 at full
        step(1, 0, 1, 0, 0, 8'hB0);
        step(1, 0, 1, 0, 0, 8'hB1);
        step(1, 0, 1, 1, 0, 8'h55);
        check("rw_full_count", 32'(count),    32'd3);
        check("rw_full_ovf",   32'(overflow), 32'd1);
        step(1, 0, 0, 0, 1, 8'h00);
        check("clear_ovf", 32'(overflow), 32'd0);

        // Count is 3: flush with a write
        step(1, 1, 1, 0, 0, 8'hC0);
        check("flush_empty", 32'(empty),    32'd1);
        check("flush_ovf",   32'(overflow), 32'd0);

        // Reset mid-traffic
        step(1, 0, 1, 0, 0, 8'hD0);
        step(1, 0, 1, 1, 0, 8'hD1);
        step(0, 0, 1, 1, 0, 8'hD2);
        check("midrst_count", 32'(count), 32'd0);

        // FWFT visibility of a single write
        step(1, 0, 1, 0, 0, 8'h77);
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_data",  32'(read_data),  32'h77);
        check("fwft_valid", 32'(read_valid), 32'd1);
`endif
        step(1, 0, 0, 1, 0, 8'h00);
        check("fwft_pop_empty", 32'(empty), 32'd1);

        // Randomized traffic with alternating write-heavy / read-heavy phases
        for (int i = 0; i < 600; i++) begin
            bit rst_n, fl, wi, ri, clr;
            int wbias;
            wbias = ((i / 40) % 2 == 0) ? 7 : 3;
            rst_n = ($urandom_range(0, 99) != 0);
            fl    = ($urandom_range(0, 29) == 0);
            clr   = ($urandom_range(0, 14) == 0);
            wi    = ($urandom_range(0, 9) < wbias);
            ri    = ($urandom_range(0, 9) >= wbias);
            if ($urandom_range(0, 4) == 0) ri = 1'b1;
            step(rst_n, fl, wi, ri, clr, 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo
